// File: rtl/contador_pkg.sv
// Shared definitions for the T flip-flop counter family: direction encodings,
// the parameter range check and the clamp rule applied to parallel-load values.
package contador_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Widest counter supported; load values are handled at this width plus one.
  localparam int MAX_W = 16;

  // True when the WIDTH/MODULO pair describes a usable counter.
  function automatic bit range_ok(input int width, input int modulo);
    return (width >= 1) && (width <= MAX_W) &&
           (modulo >= 2) && (modulo <= (1 << width));
  endfunction

  // Load values at or beyond the modulus land on the last legal count.
  function automatic logic [MAX_W:0] clamp_load(input logic [MAX_W:0] d,
                                                input logic [MAX_W:0] modulo);
    return (d < modulo) ? d : (modulo - {{MAX_W{1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/flip_flop_t_rst.sv
// One-bit T flip-flop with synchronous active-high reset and synchronous load.
// Priority: rst > ld > toggle.
module flip_flop_t_rst (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic d,
  input  logic T,
  output logic Q
);

  // Reset clears, load overrides, otherwise toggle when T is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= 1'b0;
    end else if (ld) begin
      Q <= d;
    end else begin
      Q <= Q ^ T;
    end
  end

endmodule

// File: rtl/contador_ff_t.sv
// Modulo-M up/down counter built from a bank of T flip-flops, with parallel
// load, count enable and a combinational terminal-count flag.
// Build option: define CONTADOR_SAT_EN to saturate at the ends of the range
// instead of wrapping around.
module contador_ff_t
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  if (!range_ok(WIDTH, MODULO)) begin : g_bad_params
    $error("contador_ff_t: WIDTH/MODULO out of range");
  end

  // One extra bit so MODULO = 2**WIDTH is representable and wraps cleanly.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   next_ext;
  logic             at_last;
  logic             at_zero;
  logic [WIDTH-1:0] t_vec;
  logic [MAX_W:0]   load_full;
  logic [WIDTH-1:0] load_val;
  logic             unused_bits;

  assign q_ext   = {1'b0, q};
  assign at_last = (q_ext == LAST);
  assign at_zero = (q_ext == '0);

  // Next count value; holds when disabled (load is handled by the flops).
  always_comb begin
    next_ext = q_ext;
    if (en) begin
      if (up_dn == DIR_UP) begin
        if (at_last) begin
`ifdef CONTADOR_SAT_EN
          next_ext = q_ext;
`else
          next_ext = '0;
`endif
        end else begin
          next_ext = q_ext + ONE;
        end
      end else begin
        if (at_zero) begin
`ifdef CONTADOR_SAT_EN
          next_ext = q_ext;
`else
          next_ext = LAST;
`endif
        end else begin
          next_ext = q_ext - ONE;
        end
      end
    end
  end

  // Each bit toggles exactly where the next value differs from the current one.
  assign t_vec = (load || !en) ? '0 : (q ^ next_ext[WIDTH-1:0]);

  assign load_full = clamp_load((MAX_W+1)'(d), (MAX_W+1)'(MODULO));
  assign load_val  = load_full[WIDTH-1:0];

  // High in the cycle before a wrap (or while saturated in the saturating build).
  assign tc = en & (((up_dn == DIR_UP) & at_last) | ((up_dn == DIR_DN) & at_zero));

  // Carry bit and clamp headroom are never consumed directly.
  assign unused_bits = ^{next_ext[WIDTH], load_full[MAX_W:WIDTH]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    flip_flop_t_rst u_ff (
      .clk (clk),
      .rst (rst),
      .ld  (load),
      .d   (load_val[i]),
      .T   (t_vec[i]),
      .Q   (q[i])
    );
  end

endmodule
